// File: rtl/div_ratio_ctrl.sv
// Run-time divide-ratio controller for even-ratio clock dividers.
// Ratio changes are queued and applied only at a period boundary so clk_out never glitches.
module div_ratio_ctrl #(
  parameter int MAX_HALF = 8,
  parameter int HW       = $clog2(MAX_HALF + 1),
  parameter int CW       = $clog2(2 * MAX_HALF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [HW-1:0] req_half,
  output logic          req_ready,
  output logic          clk_out,
  output logic [HW-1:0] cur_half,
  output logic          switch_done,
  output logic          req_err
);

  // state    | meaning
  // IDLE     | stopped, clk_out held low, waiting for a non-zero half-period
  // RUN      | dividing at cur_half, ready to queue a new ratio
  // RUN_PEND | dividing at cur_half, new ratio queued for the next boundary
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } state_t;

  localparam logic [HW-1:0] MAX_H = HW'(MAX_HALF);
  localparam logic [CW:0]   ONE   = (CW + 1)'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] cur_half_q, cur_half_d;
  logic [HW-1:0] pend_q, pend_d;
  logic          clk_out_q, clk_out_d;
  logic          switch_done_q, switch_done_d;
  logic          req_err_q, req_err_d;

  logic          accept;
  logic          in_range;
  logic [CW:0]   cnt_ext;
  logic [CW:0]   half_ext;
  logic          at_half;
  logic          at_end;

  assign req_ready = (state_q != RUN_PEND);
  assign accept    = req_valid & req_ready;
  assign in_range  = (req_half <= MAX_H);

  // One extra bit so 2*MAX_HALF is representable before subtracting one.
  assign cnt_ext  = {1'b0, cnt_q};
  assign half_ext = (CW + 1)'(cur_half_q);
  assign at_half  = (cnt_ext == (half_ext - ONE));
  assign at_end   = (cnt_ext == ((half_ext << 1) - ONE));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_half_d    = cur_half_q;
    pend_d        = pend_q;
    clk_out_d     = clk_out_q;
    switch_done_d = 1'b0;
    req_err_d     = accept & ~in_range;

    case (state_q)
      IDLE: begin
        clk_out_d = 1'b0;
        cnt_d     = '0;
        if (accept && in_range && (req_half != '0)) begin
          cur_half_d    = req_half;
          clk_out_d     = 1'b1;
          switch_done_d = 1'b1;
          state_d       = RUN;
        end
      end
      RUN, RUN_PEND: begin
        cnt_d = cnt_q + CW'(1);
        if (at_half) begin
          clk_out_d = 1'b0;
        end
        if (at_end) begin
          cnt_d     = '0;
          clk_out_d = 1'b1;
          if (state_q == RUN_PEND) begin
            cur_half_d    = pend_q;
            switch_done_d = 1'b1;
            pend_d        = '0;
            if (pend_q == '0) begin
              clk_out_d = 1'b0;
              state_d   = IDLE;
            end else begin
              state_d = RUN;
            end
          end
        end
        // A request landing on a boundary edge waits for the following boundary.
        if ((state_q == RUN) && accept && in_range) begin
          pend_d  = req_half;
          state_d = RUN_PEND;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cur_half_q    <= '0;
      pend_q        <= '0;
      clk_out_q     <= 1'b0;
      switch_done_q <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_half_q    <= cur_half_d;
      pend_q        <= pend_d;
      clk_out_q     <= clk_out_d;
      switch_done_q <= switch_done_d;
      req_err_q     <= req_err_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign cur_half    = cur_half_q;
  assign switch_done = switch_done_q;
  assign req_err     = req_err_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed bench for div_ratio_ctrl: start/stop, ratio switches at boundaries,
// out-of-range requests, and asynchronous reset with a queued ratio.
module tb_div_ratio_ctrl;

  localparam int HW = 4;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [HW-1:0] req_half;
  logic          req_ready;
  logic          clk_out;
  logic [HW-1:0] cur_half;
  logic          switch_done;
  logic          req_err;

  int checks = 0;
  int errors = 0;

  div_ratio_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_half    (req_half),
    .req_ready   (req_ready),
    .clk_out     (clk_out),
    .cur_half    (cur_half),
    .switch_done (switch_done),
    .req_err     (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_half  = '0;
    #2;
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_cur_half", 32'(cur_half), 0);
    chk("rst_switch_done", 32'(switch_done), 0);
    chk("rst_req_err", 32'(req_err), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    tick();
    tick();
    reset = 1'b0;

    // half=1: div2 starting high on the accept edge
    req_valid = 1'b1; req_half = 4'd1;
    tick();
    req_valid = 1'b0;
    chk("h1_e0_clk", 32'(clk_out), 1);
    chk("h1_e0_sd", 32'(switch_done), 1);
    chk("h1_e0_cur", 32'(cur_half), 1);
    tick();
    chk("h1_e1_clk", 32'(clk_out), 0);
    chk("h1_e1_sd", 32'(switch_done), 0);
    tick();
    chk("h1_e2_clk", 32'(clk_out), 1);
    tick();
    chk("h1_e3_clk", 32'(clk_out), 0);

    // stop request accepted on a boundary edge: applied at the following boundary
    req_valid = 1'b1; req_half = 4'd0;
    tick();
    req_valid = 1'b0;
    chk("stop_e4_clk", 32'(clk_out), 1);
    chk("stop_e4_ready", 32'(req_ready), 0);
    chk("stop_e4_cur", 32'(cur_half), 1);
    chk("stop_e4_sd", 32'(switch_done), 0);
    tick();
    chk("stop_e5_clk", 32'(clk_out), 0);
    chk("stop_e5_ready", 32'(req_ready), 0);
    tick();
    chk("stop_e6_clk", 32'(clk_out), 0);
    chk("stop_e6_cur", 32'(cur_half), 0);
    chk("stop_e6_sd", 32'(switch_done), 1);
    chk("stop_e6_ready", 32'(req_ready), 1);
    tick();
    chk("stop_e7_sd", 32'(switch_done), 0);
    chk("stop_e7_clk", 32'(clk_out), 0);

    // idle: request 0 is a no-op
    req_valid = 1'b1; req_half = 4'd0;
    tick();
    req_valid = 1'b0;
    chk("idle0_clk", 32'(clk_out), 0);
    chk("idle0_sd", 32'(switch_done), 0);
    chk("idle0_cur", 32'(cur_half), 0);
    chk("idle0_err", 32'(req_err), 0);
    chk("idle0_ready", 32'(req_ready), 1);

    // idle: out-of-range request
    req_valid = 1'b1; req_half = 4'd9;
    tick();
    req_valid = 1'b0;
    chk("idle9_err", 32'(req_err), 1);
    chk("idle9_clk", 32'(clk_out), 0);
    chk("idle9_cur", 32'(cur_half), 0);
    chk("idle9_ready", 32'(req_ready), 1);
    tick();
    chk("idle9_err_clr", 32'(req_err), 0);
    chk("idle9_clk2", 32'(clk_out), 0);

    // half=3 from idle, 30 cycles against the k%6 model
    req_valid = 1'b1; req_half = 4'd3;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      chk($sformatf("h3_clk_k%0d", k), 32'(clk_out), 32'((k % 6) < 3));
      chk($sformatf("h3_sd_k%0d", k), 32'(switch_done), 32'(k == 0));
    end
    chk("h3_cur", 32'(cur_half), 3);

    // request half=2 on the boundary edge of half=3: one more full half=3 period
    req_valid = 1'b1; req_half = 4'd2;
    tick();
    req_valid = 1'b0;
    chk("sw32_e30_clk", 32'(clk_out), 1);
    chk("sw32_e30_ready", 32'(req_ready), 0);
    chk("sw32_e30_cur", 32'(cur_half), 3);
    chk("sw32_e30_sd", 32'(switch_done), 0);
    for (int k = 31; k < 36; k++) begin
      tick();
      chk($sformatf("sw32_clk_k%0d", k), 32'(clk_out), 32'((k % 6) < 3));
      chk($sformatf("sw32_ready_k%0d", k), 32'(req_ready), 0);
    end
    tick();
    chk("sw32_e36_clk", 32'(clk_out), 1);
    chk("sw32_e36_sd", 32'(switch_done), 1);
    chk("sw32_e36_cur", 32'(cur_half), 2);
    chk("sw32_e36_ready", 32'(req_ready), 1);

    // running half=2, request half=3 mid-high-phase
    req_valid = 1'b1; req_half = 4'd3;
    tick();
    req_valid = 1'b0;
    chk("sw23_e37_clk", 32'(clk_out), 1);
    chk("sw23_e37_ready", 32'(req_ready), 0);
    chk("sw23_e37_cur", 32'(cur_half), 2);
    tick();
    chk("sw23_e38_clk", 32'(clk_out), 0);
    chk("sw23_e38_ready", 32'(req_ready), 0);
    tick();
    chk("sw23_e39_clk", 32'(clk_out), 0);
    chk("sw23_e39_sd", 32'(switch_done), 0);
    tick();
    chk("sw23_e40_clk", 32'(clk_out), 1);
    chk("sw23_e40_sd", 32'(switch_done), 1);
    chk("sw23_e40_cur", 32'(cur_half), 3);
    chk("sw23_e40_ready", 32'(req_ready), 1);
    for (int j = 1; j < 7; j++) begin
      tick();
      chk($sformatf("sw23_clk_j%0d", j), 32'(clk_out), 32'((j % 6) < 3));
      chk($sformatf("sw23_sd_j%0d", j), 32'(switch_done), 0);
    end

    // running: out-of-range request
    req_valid = 1'b1; req_half = 4'd9;
    tick();
    chk("run9_err", 32'(req_err), 1);
    chk("run9_clk", 32'(clk_out), 1);
    chk("run9_cur", 32'(cur_half), 3);
    chk("run9_ready", 32'(req_ready), 1);

    // queue half=5, then reset asynchronously while clk_out is high
    req_half = 4'd5;
    tick();
    req_valid = 1'b0;
    chk("pend5_err_clr", 32'(req_err), 0);
    chk("pend5_clk", 32'(clk_out), 1);
    chk("pend5_ready", 32'(req_ready), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_clk", 32'(clk_out), 0);
    chk("arst_cur", 32'(cur_half), 0);
    chk("arst_ready", 32'(req_ready), 1);
    chk("arst_sd", 32'(switch_done), 0);
    chk("arst_err", 32'(req_err), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_rst_clk_%0d", i), 32'(clk_out), 0);
      chk($sformatf("post_rst_cur_%0d", i), 32'(cur_half), 0);
      chk($sformatf("post_rst_sd_%0d", i), 32'(switch_done), 0);
    end

    // largest ratio: half=8, 16-cycle period
    req_valid = 1'b1; req_half = 4'd8;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      chk($sformatf("h8_clk_k%0d", k), 32'(clk_out), 32'((k % 16) < 8));
    end
    chk("h8_cur", 32'(cur_half), 8);
    chk("h8_err", 32'(req_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
